// File: rtl/rvv_seq_pkg.sv
// ---------------------------------------------------------------------------
// rvv_seq_pkg
//   Shared definitions for the vector ALU sequencer:
//     - seq_state_e : sequencer FSM state encoding (also exported on dbg_state)
//     - OP_VV/OP_VX/OP_VI : cmd_op_type one-hot codes
//     - ERR_* : rsp_err completion codes
//     - lane field widths used to slice the packed per-lane ALU buses
// ---------------------------------------------------------------------------
package rvv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LD   = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4,
        ST_RESP = 3'd5
    } seq_state_e;

    // Operand type, one-hot.
    localparam logic [2:0] OP_VV = 3'b001;
    localparam logic [2:0] OP_VX = 3'b010;
    localparam logic [2:0] OP_VI = 3'b100;

    // Completion codes on rsp_err.
    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_OP   = 2'd1;
    localparam logic [1:0] ERR_SEW  = 2'd2;
    localparam logic [1:0] ERR_WDOG = 2'd3;

    // Largest legal vsew code (SEW = 64).
    localparam logic [2:0] VSEW_MAX = 3'd3;

    // Per-lane field widths on the packed ALU result buses.
    localparam int VD_LANE_W = 64;
    localparam int REGI_W    = 10;

endpackage

// File: rtl/rvv_elem_merge.sv
// ---------------------------------------------------------------------------
// rvv_elem_merge
//   Combinational merge of one cycle of per-lane ALU results into the
//   result buffer.
//
//   Ports:
//     buf_in    in  VLEN           current result buffer
//     sew_code  in  2              element width code, SEW = 8 << sew_code
//     lane_vd   in  64<<NB_LANES   per-lane 64-bit results (low SEW bits used)
//     lane_regi in  10<<NB_LANES   per-lane element index
//     lane_res  in  1<<NB_LANES    per-lane result-valid
//     buf_out   out VLEN           buffer with this cycle's results applied
//
//   Lanes are applied in ascending order, so a higher lane overwrites a lower
//   one that targets the same element. An index whose element would start at
//   or beyond VLEN matches no element slot and is dropped.
// ---------------------------------------------------------------------------
module rvv_elem_merge
    import rvv_seq_pkg::*;
#(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 1
) (
    input  logic [VLEN-1:0]                buf_in,
    input  logic [1:0]                     sew_code,
    input  logic [(64<<NB_LANES)-1:0]      lane_vd,
    input  logic [(10<<NB_LANES)-1:0]      lane_regi,
    input  logic [(1<<NB_LANES)-1:0]       lane_res,
    output logic [VLEN-1:0]                buf_out
);

    localparam int LANES = 1 << NB_LANES;

    always_comb begin
        buf_out = buf_in;
        for (int k = 0; k < LANES; k++) begin
            if (lane_res[k]) begin
                case (sew_code)
                    2'd0: begin
                        for (int e = 0; e < VLEN / 8; e++) begin
                            if (int'(lane_regi[REGI_W*k +: REGI_W]) == e) begin
                                buf_out[e*8 +: 8] = lane_vd[VD_LANE_W*k +: 8];
                            end
                        end
                    end
                    2'd1: begin
                        for (int e = 0; e < VLEN / 16; e++) begin
                            if (int'(lane_regi[REGI_W*k +: REGI_W]) == e) begin
                                buf_out[e*16 +: 16] = lane_vd[VD_LANE_W*k +: 16];
                            end
                        end
                    end
                    2'd2: begin
                        for (int e = 0; e < VLEN / 32; e++) begin
                            if (int'(lane_regi[REGI_W*k +: REGI_W]) == e) begin
                                buf_out[e*32 +: 32] = lane_vd[VD_LANE_W*k +: 32];
                            end
                        end
                    end
                    default: begin
                        for (int e = 0; e < VLEN / 64; e++) begin
                            if (int'(lane_regi[REGI_W*k +: REGI_W]) == e) begin
                                buf_out[e*64 +: 64] = lane_vd[VD_LANE_W*k +: 64];
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/rvv_alu_seq.sv
// ---------------------------------------------------------------------------
// rvv_alu_seq
//   Sequencer for one vector ALU instruction: reads two source registers,
//   loads the ALU operand registers, runs the ALU while merging its per-lane
//   results into a VLEN-wide buffer, writes the buffer back and reports a
//   completion code.
//
//   FSM: IDLE -> RD -> LD -> EXEC -> WB -> RESP -> IDLE
//        IDLE -> RESP            illegal vsew (err 2)
//        EXEC -> RESP            illegal opcode on first EXEC cycle (err 1)
//                                or watchdog expiry (err 3)
//
//   Ports:
//     clk, reset                      clock, async active-high reset
//     cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//     cmd_opcode/op_type/vsew         command fields
//     cmd_vd/cmd_vs1/cmd_vs2          register indices
//     cmd_scalar                      scalar / immediate for VX / VI
//     rf_rd_addr1/2, rf_rd_data1/2    register file read (data one cycle later)
//     rf_we/rf_wr_addr/rf_wr_data     register file write (one WB cycle)
//     alu_run                         high for every EXEC cycle
//     alu_opcode/op_type/vsew         latched command fields
//     alu_vs1/alu_vs2                 operand registers
//     alu_vd/alu_regi/alu_res         per-lane results, indices, valids
//     alu_done                        ALU completion pulse
//     alu_instr_valid                 opcode legality from the ALU
//     rsp_valid/rsp_ready/rsp_err     response handshake and code
//     dbg_state                       current FSM state (seq_state_e)
//
//   Handshakes (cmd and rsp): a transfer happens on a rising clock edge where
//   valid and ready are both high. Once rsp_valid rises, it and rsp_err hold
//   steady until that transfer.
// ---------------------------------------------------------------------------
module rvv_alu_seq
    import rvv_seq_pkg::*;
#(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 1,
    parameter int WDOG_MAX = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [5:0]                    cmd_opcode,
    input  logic [2:0]                    cmd_op_type,
    input  logic [2:0]                    cmd_vsew,
    input  logic [4:0]                    cmd_vd,
    input  logic [4:0]                    cmd_vs1,
    input  logic [4:0]                    cmd_vs2,
    input  logic [63:0]                   cmd_scalar,
    output logic [4:0]                    rf_rd_addr1,
    output logic [4:0]                    rf_rd_addr2,
    input  logic [VLEN-1:0]               rf_rd_data1,
    input  logic [VLEN-1:0]               rf_rd_data2,
    output logic                          rf_we,
    output logic [4:0]                    rf_wr_addr,
    output logic [VLEN-1:0]               rf_wr_data,
    output logic                          alu_run,
    output logic [5:0]                    alu_opcode,
    output logic [2:0]                    alu_op_type,
    output logic [2:0]                    alu_vsew,
    output logic [VLEN-1:0]               alu_vs1,
    output logic [VLEN-1:0]               alu_vs2,
    input  logic [(64<<NB_LANES)-1:0]     alu_vd,
    input  logic [(10<<NB_LANES)-1:0]     alu_regi,
    input  logic [(1<<NB_LANES)-1:0]      alu_res,
    input  logic                          alu_done,
    input  logic                          alu_instr_valid,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_err,
    output logic [2:0]                    dbg_state
);

    localparam int                 WDOG_W    = $clog2(WDOG_MAX + 1);
    // EXEC gives up at the end of its WDOG_MAX-th cycle.
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

    seq_state_e          state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic [4:0]          vd_q, vs1_q, vs2_q;
    logic [63:0]         scalar_q;
    logic [VLEN-1:0]     buf_q, buf_merged;
    logic [VLEN-1:0]     scalar_rep;
    logic [WDOG_W-1:0]   wdog_q;
    logic                exec_first;
    logic                use_scalar;

    // The watchdog is cleared in LD, so a zero count marks the first EXEC cycle.
    assign exec_first = (wdog_q == '0);
    assign use_scalar = (alu_op_type == OP_VX) || (alu_op_type == OP_VI);

    // Low SEW bits of the scalar, replicated across the whole register.
    always_comb begin
        case (alu_vsew[1:0])
            2'd0:    scalar_rep = {(VLEN/8){scalar_q[7:0]}};
            2'd1:    scalar_rep = {(VLEN/16){scalar_q[15:0]}};
            2'd2:    scalar_rep = {(VLEN/32){scalar_q[31:0]}};
            default: scalar_rep = {(VLEN/64){scalar_q}};
        endcase
    end

    rvv_elem_merge #(
        .VLEN     (VLEN),
        .NB_LANES (NB_LANES)
    ) u_merge (
        .buf_in    (buf_q),
        .sew_code  (alu_vsew[1:0]),
        .lane_vd   (alu_vd),
        .lane_regi (alu_regi),
        .lane_res  (alu_res),
        .buf_out   (buf_merged)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    // err_d travels with the transition so rsp_err is settled on RESP entry
    // and is left untouched while RESP waits for rsp_ready.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_vsew > VSEW_MAX) begin
                        state_d = ST_RESP;
                        err_d   = ERR_SEW;
                    end else begin
                        state_d = ST_RD;
                        err_d   = ERR_OK;
                    end
                end
            end
            ST_RD:   state_d = ST_LD;
            ST_LD:   state_d = ST_EXEC;
            ST_EXEC: begin
                // Illegal opcode beats everything; a done in the same cycle
                // as watchdog expiry still completes normally.
                if (exec_first && !alu_instr_valid) begin
                    state_d = ST_RESP;
                    err_d   = ERR_OP;
                end else if (alu_done) begin
                    state_d = ST_WB;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_RESP;
                    err_d   = ERR_WDOG;
                end
            end
            ST_WB: begin
                state_d = ST_RESP;
                err_d   = ERR_OK;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rf_we     = (state_q == ST_WB);
        alu_run   = (state_q == ST_EXEC);
        rsp_valid = (state_q == ST_RESP);
    end

    assign rf_rd_addr1 = vs1_q;
    assign rf_rd_addr2 = vs2_q;
    assign rf_wr_addr  = vd_q;
    assign rf_wr_data  = buf_q;
    assign rsp_err     = err_q;
    assign dbg_state   = state_q;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q       <= ERR_OK;
            alu_opcode  <= '0;
            alu_op_type <= '0;
            alu_vsew    <= '0;
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            scalar_q    <= '0;
            alu_vs1     <= '0;
            alu_vs2     <= '0;
            buf_q       <= '0;
            wdog_q      <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_opcode  <= cmd_opcode;
                        alu_op_type <= cmd_op_type;
                        alu_vsew    <= cmd_vsew;
                        vd_q        <= cmd_vd;
                        vs1_q       <= cmd_vs1;
                        vs2_q       <= cmd_vs2;
                        scalar_q    <= cmd_scalar;
                    end
                end
                ST_LD: begin
                    alu_vs2 <= rf_rd_data2;
                    alu_vs1 <= use_scalar ? scalar_rep : rf_rd_data1;
                    buf_q   <= '0;
                    wdog_q  <= '0;
                end
                ST_EXEC: begin
                    buf_q  <= buf_merged;
                    wdog_q <= wdog_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_alu_seq.sv
module tb_rvv_alu_seq;
    import rvv_seq_pkg::*;

    localparam int VLEN     = 128;
    localparam int NB_LANES = 1;
    localparam int LANES    = 1 << NB_LANES;
    localparam int WDOG_MAX = 1023;

    // ------------------------------------------------------------ signals
    logic                      clk;
    logic                      reset;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [5:0]                cmd_opcode;
    logic [2:0]                cmd_op_type;
    logic [2:0]                cmd_vsew;
    logic [4:0]                cmd_vd, cmd_vs1, cmd_vs2;
    logic [63:0]               cmd_scalar;
    logic [4:0]                rf_rd_addr1, rf_rd_addr2;
    logic [VLEN-1:0]           rf_rd_data1, rf_rd_data2;
    logic                      rf_we;
    logic [4:0]                rf_wr_addr;
    logic [VLEN-1:0]           rf_wr_data;
    logic                      alu_run;
    logic [5:0]                alu_opcode;
    logic [2:0]                alu_op_type;
    logic [2:0]                alu_vsew;
    logic [VLEN-1:0]           alu_vs1, alu_vs2;
    logic [(64<<NB_LANES)-1:0] alu_vd;
    logic [(10<<NB_LANES)-1:0] alu_regi;
    logic [(1<<NB_LANES)-1:0]  alu_res;
    logic                      alu_done;
    logic                      alu_instr_valid;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_err;
    logic [2:0]                dbg_state;

    rvv_alu_seq #(
        .VLEN     (VLEN),
        .NB_LANES (NB_LANES),
        .WDOG_MAX (WDOG_MAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_op_type     (cmd_op_type),
        .cmd_vsew        (cmd_vsew),
        .cmd_vd          (cmd_vd),
        .cmd_vs1         (cmd_vs1),
        .cmd_vs2         (cmd_vs2),
        .cmd_scalar      (cmd_scalar),
        .rf_rd_addr1     (rf_rd_addr1),
        .rf_rd_addr2     (rf_rd_addr2),
        .rf_rd_data1     (rf_rd_data1),
        .rf_rd_data2     (rf_rd_data2),
        .rf_we           (rf_we),
        .rf_wr_addr      (rf_wr_addr),
        .rf_wr_data      (rf_wr_data),
        .alu_run         (alu_run),
        .alu_opcode      (alu_opcode),
        .alu_op_type     (alu_op_type),
        .alu_vsew        (alu_vsew),
        .alu_vs1         (alu_vs1),
        .alu_vs2         (alu_vs2),
        .alu_vd          (alu_vd),
        .alu_regi        (alu_regi),
        .alu_res         (alu_res),
        .alu_done        (alu_done),
        .alu_instr_valid (alu_instr_valid),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_err         (rsp_err),
        .dbg_state       (dbg_state)
    );

    // ------------------------------------------------------ clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // --------------------------------------------------------- scoreboard
    int total = 0;
    int bad   = 0;
    logic [132:0] exp_wr_q[$];   // {addr, data}
    logic [1:0]   exp_rsp_q[$];
    logic [132:0] wr_exp_v;
    logic [1:0]   rsp_exp_v;
    int run_cycles = 0;
    int wr_seen    = 0;
    int rsp_seen   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: counts EXEC cycles and compares every write / response.
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_run) run_cycles++;
            if (rf_we) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rf_write: got addr=%0d data=%h expected no write", rf_wr_addr, rf_wr_data);
                end else begin
                    wr_exp_v = exp_wr_q.pop_front();
                    check("rf_write", 160'({rf_wr_addr, rf_wr_data}), 160'(wr_exp_v));
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (exp_rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp: got err=%0d expected no response", rsp_err);
                end else begin
                    rsp_exp_v = exp_rsp_q.pop_front();
                    check("rsp_err", 160'(rsp_err), 160'(rsp_exp_v));
                end
            end
        end
    end

    // ------------------------------------------- register file / ALU models
    logic [VLEN-1:0] rf_mem [32];
    int              alu_mode;     // 0 normal, 1 illegal op, 2 never done, 3 lane collision, 4 out of range
    int              alu_cnt = 0;
    logic [VLEN-1:0] cap_vs1;

    always @(negedge clk) begin
        rf_rd_data1 = rf_mem[rf_rd_addr1];
        rf_rd_data2 = rf_mem[rf_rd_addr2];
    end

    function automatic logic [63:0] elem_sum(input int idx);
        int sew;
        logic [VLEN-1:0] a, b;
        sew = 8 << alu_vsew;
        a = alu_vs1 >> (idx * sew);
        b = alu_vs2 >> (idx * sew);
        return a[63:0] + b[63:0];
    endfunction

    // Two lanes, one element per lane per cycle, done with the last pair.
    always @(negedge clk) begin
        int nel;
        alu_res         = '0;
        alu_done        = 1'b0;
        alu_vd          = '0;
        alu_regi        = '0;
        alu_instr_valid = 1'b1;
        if (alu_run) begin
            if (alu_cnt == 0) cap_vs1 = alu_vs1;
            if (alu_mode == 1) alu_instr_valid = 1'b0;
            nel = VLEN >> (3 + int'(alu_vsew));
            if (alu_mode == 0 || alu_mode >= 3) begin
                if (2 * alu_cnt < nel) begin
                    for (int k = 0; k < LANES; k++) begin
                        alu_res[k]            = 1'b1;
                        alu_regi[10*k +: 10]  = 10'(2 * alu_cnt + k);
                        alu_vd[64*k +: 64]    = elem_sum(2 * alu_cnt + k);
                    end
                    if (alu_mode == 0 && 2 * alu_cnt + 2 >= nel) alu_done = 1'b1;
                end else if (2 * alu_cnt == nel) begin
                    alu_done = 1'b1;
                    alu_res  = '1;
                    if (alu_mode == 3) begin
                        alu_regi[9:0]   = 10'd0;
                        alu_regi[19:10] = 10'd0;
                        alu_vd[63:0]    = '1;
                        alu_vd[127:64]  = elem_sum(0);
                    end else begin
                        alu_regi[9:0]   = 10'(nel);
                        alu_regi[19:10] = 10'd1023;
                        alu_vd          = '1;
                    end
                end
            end
            alu_cnt++;
        end else begin
            alu_cnt = 0;
        end
    end

    // ------------------------------------------------------- driver tasks
    task automatic send_cmd(input logic [2:0] op_type, input logic [2:0] vsew, input logic [4:0] vd,
                            input logic [4:0] vs1, input logic [4:0] vs2, input logic [63:0] scalar);
        int n = 0;
        cmd_valid   = 1'b1;
        cmd_opcode  = 6'h00;
        cmd_op_type = op_type;
        cmd_vsew    = vsew;
        cmd_vd      = vd;
        cmd_vs1     = vs1;
        cmd_vs2     = vs2;
        cmd_scalar  = scalar;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) begin
            total++;
            bad++;
            $display("FAIL cmd_accept: got no cmd_ready in 100 cycles expected acceptance");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int target, input int budget);
        int n = 0;
        while (rsp_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (rsp_seen < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d responses expected %0d", name, rsp_seen, target);
        end
    endtask

    task automatic run_op(input string name, input int mode, input logic [2:0] op_type, input logic [2:0] vsew,
                          input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                          input logic [63:0] scalar, input logic [1:0] exp_err, input logic do_wr,
                          input logic [VLEN-1:0] exp_data, output int run_delta);
        int w0, r0, target;
        alu_mode = mode;
        cap_vs1  = '0;
        if (do_wr) exp_wr_q.push_back({vd, exp_data});
        exp_rsp_q.push_back(exp_err);
        w0     = wr_seen;
        r0     = run_cycles;
        target = rsp_seen + 1;
        send_cmd(op_type, vsew, vd, vs1, vs2, scalar);
        wait_rsp(name, target, 3000);
        check({name, "_wr_count"}, 160'(wr_seen - w0), 160'(do_wr));
        run_delta = run_cycles - r0;
        @(posedge clk); #1;
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        int rd;
        int w0, r0, s0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_opcode  = '0;
        cmd_op_type = '0;
        cmd_vsew    = '0;
        cmd_vd      = '0;
        cmd_vs1     = '0;
        cmd_vs2     = '0;
        cmd_scalar  = '0;
        rsp_ready   = 1'b1;
        alu_mode    = 0;
        cap_vs1     = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rf_mem[1] = 128'h0102030405060708090a0b0c0d0e0f10;
        rf_mem[2] = 128'h10101010101010101010101010101010;
        rf_mem[4] = 128'hffffffffffffffffffffffffffffffff;
        rf_mem[5] = 128'h01010101010101010101010101010101;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 160'(cmd_ready), 160'(1'b1));
        check("rst_rsp_valid", 160'(rsp_valid), 160'(1'b0));
        check("rst_rf_we",     160'(rf_we),     160'(1'b0));
        check("rst_alu_run",   160'(alu_run),   160'(1'b0));
        check("rst_rsp_err",   160'(rsp_err),   160'(2'd0));
        check("rst_state",     160'(dbg_state), 160'(ST_IDLE));
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", 160'(cmd_ready), 160'(1'b1));

        // VV vadd SEW=8: 16 bytes over 8 two-lane cycles.
        run_op("vv_sew8", 0, OP_VV, 3'd0, 5'd3, 5'd1, 5'd2, 64'd0, ERR_OK, 1'b1,
               128'h1112131415161718191a1b1c1d1e1f20, rd);
        check("vv_sew8_exec_cycles", 160'(rd), 160'(8));

        // VX SEW=32: scalar low word replicated.
        run_op("vx_sew32", 0, OP_VX, 3'd2, 5'd6, 5'd0, 5'd2, 64'h12345678deadbeef, ERR_OK, 1'b1,
               128'heebdceffeebdceffeebdceffeebdceff, rd);
        check("vx_sew32_vs1", 160'(cap_vs1), 160'(128'hdeadbeefdeadbeefdeadbeefdeadbeef));
        check("vx_sew32_exec_cycles", 160'(rd), 160'(2));

        // VI SEW=16 with a lane collision on element 0 (lane 1 must win).
        run_op("vi_sew16", 3, OP_VI, 3'd1, 5'd9, 5'd0, 5'd1, 64'hffffffffffff0005, ERR_OK, 1'b1,
               128'h0107_0309_050b_070d_090f_0b11_0d13_0f15, rd);
        check("vi_sew16_vs1", 160'(cap_vs1), 160'(128'h00050005000500050005000500050005));
        check("vi_sew16_exec_cycles", 160'(rd), 160'(5));

        // VV SEW=64 with out-of-range indices on the done cycle.
        run_op("vv_sew64", 4, OP_VV, 3'd3, 5'd10, 5'd4, 5'd5, 64'd0, ERR_OK, 1'b1,
               128'h0101010101010100_0101010101010100, rd);
        check("vv_sew64_exec_cycles", 160'(rd), 160'(2));

        // Illegal vsew with the response held off for 5 cycles.
        rsp_ready = 1'b0;
        alu_mode  = 0;
        exp_rsp_q.push_back(ERR_SEW);
        w0 = wr_seen;
        r0 = run_cycles;
        s0 = rsp_seen;
        send_cmd(OP_VV, 3'd5, 5'd11, 5'd1, 5'd2, 64'd0);
        check("sew_err_rsp_valid_at_accept", 160'(rsp_valid), 160'(1'b1));
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 160'(rsp_valid), 160'(1'b1));
            check("hold_rsp_err",   160'(rsp_err),   160'(ERR_SEW));
            check("hold_cmd_ready", 160'(cmd_ready), 160'(1'b0));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_rsp("sew_err", s0 + 1, 50);
        check("sew_err_exec_cycles", 160'(run_cycles - r0), 160'(0));
        check("sew_err_wr_count",    160'(wr_seen - w0),    160'(0));
        @(posedge clk); #1;

        // Illegal opcode reported on the first EXEC cycle.
        run_op("ill_op", 1, OP_VV, 3'd0, 5'd12, 5'd1, 5'd2, 64'd0, ERR_OP, 1'b0, '0, rd);
        check("ill_op_exec_cycles", 160'(rd), 160'(1));

        // ALU never finishes: watchdog.
        run_op("wdog", 2, OP_VV, 3'd0, 5'd13, 5'd1, 5'd2, 64'd0, ERR_WDOG, 1'b0, '0, rd);
        check("wdog_exec_cycles", 160'(rd), 160'(WDOG_MAX));

        // Reset in the middle of EXEC: no write, no response.
        alu_mode = 2;
        w0 = wr_seen;
        s0 = rsp_seen;
        send_cmd(OP_VV, 3'd0, 5'd14, 5'd1, 5'd2, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_reset_in_exec", 160'(alu_run), 160'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_alu_run",   160'(alu_run),    160'(1'b0));
        check("mid_reset_rsp_valid", 160'(rsp_valid),  160'(1'b0));
        check("mid_reset_rf_we",     160'(rf_we),      160'(1'b0));
        check("mid_reset_cmd_ready", 160'(cmd_ready),  160'(1'b1));
        check("mid_reset_state",     160'(dbg_state),  160'(ST_IDLE));
        check("mid_reset_alu_vs1",   160'(alu_vs1),    160'(128'd0));
        check("mid_reset_wr_data",   160'(rf_wr_data), 160'(128'd0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_reset_no_write", 160'(wr_seen - w0),  160'(0));
        check("mid_reset_no_rsp",   160'(rsp_seen - s0), 160'(0));

        // Next command after the abandoned one completes normally.
        run_op("after_reset", 0, OP_VV, 3'd0, 5'd15, 5'd1, 5'd1, 64'd0, ERR_OK, 1'b1,
               128'h020406080a0c0e10121416181a1c1e20, rd);
        check("after_reset_exec_cycles", 160'(rd), 160'(8));

        repeat (3) @(posedge clk);
        check("wr_queue_drained",  160'(exp_wr_q.size()),  160'(0));
        check("rsp_queue_drained", 160'(exp_rsp_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvv_alu_seq.md
RVV_ALU_SEQ -- requirements
Module: rvv_alu_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter NB_LANES, default 1, log2 of ALU lane count.
REQ-003 SHALL have parameter WDOG_MAX, default 1023, maximum EXEC cycles before abort.
REQ-004 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  single clock; one clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_opcode  in  6  ALU opcode.
- cmd_op_type  in  3  VV=001, VX=010, VI=100.
- cmd_vsew  in  3  element width code; SEW=8<<vsew.
- cmd_vd/cmd_vs1/cmd_vs2  in  5 each  register indices.
- cmd_scalar  in  64  scalar/immediate operand for VX/VI.
- rf_rd_addr1/rf_rd_addr2  out  5 each  register-file read addresses.
- rf_rd_data1/rf_rd_data2  in  VLEN each  read data, valid one cycle after address.
- rf_we  out  1  write enable.
- rf_wr_addr  out  5  write address.
- rf_wr_data  out  VLEN  write data.
- alu_run  out  1  ALU run.
- alu_opcode/alu_op_type/alu_vsew  out  6/3/3  registered copies of the command fields.
- alu_vs1/alu_vs2  out  VLEN each  operand registers.
- alu_vd  in  64<<NB_LANES  per-lane 64-bit results.
- alu_regi  in  10<<NB_LANES  per-lane element index.
- alu_res  in  1<<NB_LANES  per-lane result-valid.
- alu_done  in  1  ALU completion pulse.
- alu_instr_valid  in  1  opcode legality.
- rsp_valid/rsp_ready  out/in  1/1  response handshake.
- rsp_err  out  2  0=ok, 1=illegal opcode, 2=illegal vsew, 3=watchdog.

Function
REQ-005 SHALL implement the FSM IDLE -> RD -> LD -> EXEC -> WB -> RESP -> IDLE, with one state per cycle except EXEC and RESP.
REQ-006 IDLE: cmd_ready=1 only in IDLE; when cmd_valid=1, SHALL latch all cmd_* fields. If cmd_vsew>3, SHALL go to RESP with err=2. Otherwise SHALL go to RD.
REQ-007 RD: rf_rd_addr1=vs1, rf_rd_addr2=vs2.
REQ-008 LD: alu_vs2<=rf_rd_data2. For VV, alu_vs1<=rf_rd_data1. For VX/VI, alu_vs1<=low SEW bits of cmd_scalar replicated VLEN/SEW times. SHALL clear the result buffer to zero.
REQ-009 EXEC: alu_run=1 for every cycle in EXEC, and 0 in all other states.
REQ-010 EXEC merge: each cycle, for each lane k with alu_res[k]=1, SHALL write buffer bits [regi_k*SEW +: SEW] with alu_vd[64k +: SEW]. Later lanes win on an index collision. Indices with regi_k*SEW>=VLEN SHALL be ignored.
REQ-011 EXEC exit: results arriving in the cycle alu_done=1 SHALL be merged, then go to WB.
REQ-012 EXEC abort: if alu_instr_valid=0 in the first EXEC cycle, SHALL go to RESP with err=1, no write-back.
REQ-013 Watchdog: SHALL count cycles in EXEC. If the count reaches WDOG_MAX with no alu_done, SHALL go to RESP with err=3, no write-back. Simultaneous alu_done and WDOG_MAX: alu_done wins.
REQ-014 WB: rf_we=1 for exactly one cycle, rf_wr_addr=vd, rf_wr_data=buffer; then go to RESP with err=0.
REQ-015 RESP: SHALL hold rsp_valid=1 and a stable rsp_err until rsp_ready=1, then go to IDLE. If rsp_ready is already 1 on entry, the stay in RESP is 1 cycle.
REQ-016 SHALL accept no command outside IDLE; back-to-back commands are spaced by at least 6 cycles.

Reset
REQ-017 Reset SHALL be asynchronous: state=IDLE; cmd_ready=1 after deassertion; rsp_valid, rf_we and alu_run =0; rsp_err, operand registers, buffer and watchdog =0.
REQ-018 Reset asserted mid-operation SHALL abandon the command with no rf write and no response.

Structure
REQ-019 Package rvv_seq_pkg SHALL hold the FSM state encoding, the op_type constants VV/VX/VI, and the rsp_err codes.
REQ-020 Element merge SHALL be the sub-module rvv_elem_merge (combinational, parameters VLEN/NB_LANES).

Verification
REQ-021 VV vadd, vsew=0, VLEN=128, NB_LANES=1, ALU model with 8 cycles + done: exactly one rf_we to vd with all 16 bytes merged, rsp_err=0.
REQ-022 VX, vsew=2, cmd_scalar=0x...DEADBEEF: alu_vs1=0xDEADBEEF x4 during EXEC.
REQ-023 cmd_vsew=5: no alu_run, no rf_we, RESP with err=2 within 2 cycles of acceptance.
REQ-024 alu_instr_valid=0 on the first EXEC cycle: err=1, no rf_we; alu_done never asserted: err=3 after WDOG_MAX cycles.
REQ-025 rsp_ready held low 5 cycles: rsp_valid and rsp_err stable, cmd_ready=0 throughout.
REQ-026 reset pulse during EXEC: all outputs at reset values immediately; the next command completes normally.
